// File: rtl/bhand_ser.sv
// Wide-to-narrow handshake serializer: one IN_WIDTH word in, RATIO OUT_WIDTH beats out,
// most-significant beat first, with short last words trimmed to their valid beats.
module bhand_ser #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned RATIO     = IN_WIDTH / OUT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_WIDTH-1:0]        idata,
  input  logic                       idata_last,
  input  logic [$clog2(RATIO)-1:0]   idata_nbeats,
  input  logic                       idata_vld,
  output logic                       idata_rdy,
  output logic [OUT_WIDTH-1:0]       odata,
  output logic                       odata_last,
  output logic                       odata_vld,
  input  logic                       odata_rdy
);

  localparam int unsigned RW = $clog2(RATIO + 1);

  logic [IN_WIDTH-1:0] sr_q, sr_d;
  logic [RW-1:0]       rem_q, rem_d;
  logic                full_q, full_d;
  logic                last_q, last_d;
  logic                olast_q, olast_d;
  logic [RW-1:0]       nb_dec;
  logic                in_acc, out_acc, on_final;

  assign on_final  = (rem_q == RW'(1));
  assign idata_rdy = !rst && (!full_q || (odata_rdy && on_final));
  assign in_acc    = idata_vld && idata_rdy;
  assign out_acc   = full_q && odata_rdy;

  // A zero beat count on a last word means a full word.
  assign nb_dec = (idata_nbeats == '0) ? RW'(RATIO) : RW'(idata_nbeats);

  always_comb begin
    sr_d   = sr_q;
    rem_d  = rem_q;
    full_d = full_q;
    last_d = last_q;
    if (in_acc) begin
      // Load wins over the final-beat drain so back-to-back words have no bubble.
      sr_d   = idata;
      rem_d  = idata_last ? nb_dec : RW'(RATIO);
      last_d = idata_last;
      full_d = 1'b1;
    end else if (out_acc) begin
      if (!on_final) begin
        sr_d  = sr_q << OUT_WIDTH;
        rem_d = rem_q - RW'(1);
      end else begin
        full_d = 1'b0;
      end
    end
    olast_d = full_d && last_d && (rem_d == RW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      rem_q   <= '0;
      full_q  <= 1'b0;
      last_q  <= 1'b0;
      olast_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      full_q  <= full_d;
      last_q  <= last_d;
      olast_q <= olast_d;
    end
  end

  assign odata      = sr_q[IN_WIDTH-1 -: OUT_WIDTH];
  assign odata_vld  = full_q;
  assign odata_last = olast_q;

endmodule

// File: tb/tb_bhand_ser.sv
// Directed and randomized bench for bhand_ser; the expected output stream is a queue of
// {last, byte} entries built from each accepted word.
module tb_bhand_ser;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] idata;
  logic        idata_last;
  logic [1:0]  idata_nbeats;
  logic        idata_vld;
  logic        idata_rdy;
  logic [7:0]  odata;
  logic        odata_last;
  logic        odata_vld;
  logic        odata_rdy;

  int n_checks = 0;
  int n_err    = 0;
  bit rand_rdy = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [8:0] q[$];

  always #5 clk = ~clk;

  bhand_ser dut (
    .clk          (clk),
    .rst          (rst),
    .idata        (idata),
    .idata_last   (idata_last),
    .idata_nbeats (idata_nbeats),
    .idata_vld    (idata_vld),
    .idata_rdy    (idata_rdy),
    .odata        (odata),
    .odata_last   (odata_last),
    .odata_vld    (odata_vld),
    .odata_rdy    (odata_rdy)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the beats a word should produce: full words give 4, a last word gives nbeats (0 => 4).
  task automatic push_word(input logic [31:0] w, input logic l, input logic [1:0] nb);
    int n;
    n = (l && nb != 2'd0) ? int'(nb) : 4;
    for (int i = 0; i < n; i++) q.push_back({l && (i == n - 1), w[31 - 8*i -: 8]});
  endtask

  // One clock cycle: check outputs against the model, then advance the model over the edge.
  task automatic cyc(output bit acc);
    bit exp_rdy, pop;
    @(negedge clk);
    if (rand_rdy) odata_rdy = 1'($urandom_range(0, 1));
    #1;
    exp_rdy = !rst && (q.size() == 0 || (q.size() == 1 && odata_rdy));
    chk(32'(idata_rdy), 32'(exp_rdy), "idata_rdy");
    chk(32'(odata_vld), 32'(q.size() > 0), "odata_vld");
    if (q.size() > 0) begin
      chk(32'(odata), 32'(q[0][7:0]), "odata");
      chk(32'(odata_last), 32'(q[0][8]), "odata_last");
    end
    if (prev_stall) chk(32'(odata), 32'(prev_data), "stall_stable");
    prev_stall = odata_vld && !odata_rdy;
    prev_data  = odata;
    acc = idata_vld && exp_rdy;
    pop = (q.size() > 0) && odata_rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) push_word(idata, idata_last, idata_nbeats);
    end
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic l, input logic [1:0] nb,
                      output int ncyc);
    bit acc = 1'b0;
    idata = w; idata_last = l; idata_nbeats = nb; idata_vld = 1'b1;
    ncyc = 0;
    while (!acc && ncyc < 200) begin
      cyc(acc);
      ncyc++;
    end
    if (!acc) begin
      n_checks++; n_err++;
      $error("FAIL send_timeout observed=no_accept expected=accept");
    end
    idata_vld = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    idata_vld = 1'b0;
    while (q.size() > 0 && n < 200) begin
      cyc(acc);
      n++;
    end
    chk(32'(q.size()), 32'd0, "drain_empty");
    cyc(acc);
  endtask

  initial begin
    bit acc;
    int nc, nw;
    rst = 1'b1; idata = 32'hDEADBEEF; idata_last = 1'b0; idata_nbeats = 2'd0;
    idata_vld = 1'b1; odata_rdy = 1'b1;
    #1;
    // Word offered during reset must not be taken.
    for (int i = 0; i < 3; i++) cyc(acc);
    rst = 1'b0;
    chk(32'(odata), 32'h0, "reset_odata");
    chk(32'(odata_last), 32'h0, "reset_odata_last");
    chk(32'(odata_vld), 32'h0, "reset_odata_vld");
    chk(32'(q.size()), 32'd0, "reset_no_accept");

    send(32'hDEADBEEF, 1'b0, 2'd0, nc);
    chk(32'(nc), 32'd1, "first_accept_cycle");
    drain();

    send(32'h01020304, 1'b0, 2'd0, nc);
    send(32'h05060708, 1'b1, 2'd0, nc);
    chk(32'(nc), 32'd4, "b2b_second_accept_cycle");
    drain();

    send(32'hAABBCCDD, 1'b1, 2'd3, nc);
    drain();
    send(32'hAABBCCDD, 1'b1, 2'd1, nc);
    drain();

    // Reset after two of four beats: remaining beats must vanish.
    send(32'hDEADBEEF, 1'b0, 2'd0, nc);
    cyc(acc);
    cyc(acc);
    odata_rdy = 1'b0; rst = 1'b1;
    cyc(acc);
    rst = 1'b0; odata_rdy = 1'b1;
    cyc(acc);
    send(32'h11223344, 1'b1, 2'd0, nc);
    drain();

    rand_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        send($urandom, w == nw - 1, 2'($urandom_range(0, 3)), nc);
        if ($urandom_range(0, 7) == 0) cyc(acc);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bhand_ser.md
# bhand_ser

Width-down converter with valid/ready handshakes on both sides. It accepts one wide word per transfer and emits it as RATIO narrow beats, most-significant beat first (network byte order). It sits at the transmit end of a wide buffered-handshake pipeline and feeds narrow consumers such as a byte-wide packet forwarder. A short final word of a packet is emitted with only its valid beats, and `odata_last` marks the final beat.

## Interface
- `IN_WIDTH`, 32: input word width; must equal `RATIO*OUT_WIDTH`
- `OUT_WIDTH`, 8: output beat width
- `RATIO`, 4 (derived, `IN_WIDTH/OUT_WIDTH`): beats per word; must be ≥2
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: reset, synchronous, active-high
- `idata` in IN_WIDTH: wide input word; bits [IN_WIDTH-1 -: OUT_WIDTH] are beat 0
- `idata_last` in 1: word is the last of a packet
- `idata_nbeats` in $clog2(RATIO): valid beats in a last word, 0 encodes RATIO; ignored when `idata_last`=0
- `idata_vld` in 1: input valid
- `idata_rdy` out 1: input ready
- `odata` out OUT_WIDTH: current beat
- `odata_last` out 1: final beat of a packet
- `odata_vld` out 1: output valid
- `odata_rdy` in 1: output ready

## Operation
- Transfers occur on a cycle where vld and rdy are both 1, sampled at the clock edge.
- Internal state consists of:
  - a wide shift register `sr`;
  - a beat down-counter `rem` (beats remaining including the current one);
  - a holding flag `full`;
  - a latched `last` flag.
- The block has two states:
  - EMPTY (`full`=0): `idata_rdy`=1 and `odata_vld`=0.
  - BUSY (`full`=1): `odata_vld`=1 and `odata` = `sr[IN_WIDTH-1 -: OUT_WIDTH]`.
- `idata_rdy` = !rst && (!full || (odata_rdy && rem==1)). A combinational path from `odata_rdy` to `idata_rdy` is permitted.
- On input accept:
  - `sr` ← `idata`.
  - `rem` ← RATIO, or ← the decoded `idata_nbeats` when `idata_last`=1.
  - `last` ← `idata_last`.
  - `full` ← 1.
- On output accept with rem>1:
  - `sr` ← `sr << OUT_WIDTH`, zero-filled.
  - `rem` ← rem−1.
- On output accept with rem==1 and no simultaneous input accept: `full` ← 0.
- Simultaneous final-beat output accept and input accept: the load takes priority and `full` stays 1, so there is no bubble.
- `odata_last` = full && last && rem==1.
- Beats of a short last word beyond `nbeats` are never emitted.
- `odata` remains stable while `odata_vld`=1 and `odata_rdy`=0. The input word is never modified in flight.
- `idata_vld` dropping mid-stream has no effect on beats already held.
- No upper bound on packet length; `last` flags simply pass through.

## Timing
- Reset values:
  - `odata_vld`=0, `odata`=0, `odata_last`=0.
  - `sr`=0, `rem`=0, `full`=0.
  - `idata_rdy`=0 while `rst`=1, and 1 on the first cycle after release.
- Reset asserted mid-word: the held beats are discarded and no partial packet is emitted afterward.
- Latency: an input accepted at edge N gives beat 0 valid in the cycle following edge N, i.e. 1 cycle.
- Throughput with `odata_rdy` held at 1 is one beat per cycle, continuously. For full words this is one input word every RATIO cycles.
- A last word with `nbeats`=k occupies the output for exactly k cycles under no backpressure.
- Backpressure on `odata_rdy` stalls the beat in place. `idata_rdy` stays 0 until the final beat is being accepted.
- All outputs except `idata_rdy` are registered.

## Test plan
- Reset, then accept `idata`=0xDEADBEEF with `last`=0 and `odata_rdy`=1 → `odata` = 0xDE, 0xAD, 0xBE, 0xEF on 4 consecutive cycles starting 1 cycle after accept; `odata_last`=0 throughout.
- Back-to-back words 0x01020304 then 0x05060708 (last=1, nbeats=0), `idata_vld` held at 1 → 8 contiguous beats 0x01..0x08 with no gap; `idata_rdy`=1 exactly on the 0x04 and 0x08 final-beat cycles; `odata_last`=1 only on 0x08.
- Short last word 0xAABBCCDD with last=1, nbeats=3 → beats 0xAA, 0xBB, 0xCC; `odata_last`=1 on 0xCC; then `odata_vld`=0. With nbeats=1 → single beat 0xAA carrying `odata_last`=1.
- Random `odata_rdy` at 50% over 1000 random packets → the output stream equals the reference model byte for byte; `odata` is stable whenever vld=1 and rdy=0; no beat is dropped or duplicated.
- Assert `rst` after 2 of 4 beats have been emitted → the following cycle has `odata_vld`=0; after release, the next word's beat 0 is emitted correctly; no stale 0xBE or 0xEF appears.
- `idata_vld`=1 while `rst`=1 → `idata_rdy`=0 and no word is accepted; the first accept happens on the first cycle after release.
